// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl -- byte-serial arbiter between the LSB / instruction fetch and an
// 8-bit synchronous RAM/IO bus.
//
// A 1/2/4-byte load, store or 4-byte fetch is broken into consecutive byte
// cycles at base, base+1, ... Read data is assembled LSB first and returned
// zero-extended. Priority in IDLE: pending store, live store pulse, LSB
// load, fetch. A store pulse that arrives while the bus is busy is parked
// in a one-deep buffer and issued ahead of everything else once idle.
//
// Optional build macro: MEM_IO_STALL_EN
//   defined   : a store into IO space (addr[17:16] == IO_TAG) holds its
//               current byte, with the strobe low, while io_full is high.
//   undefined : io_full is ignored.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   rdy                0 = freeze every register, strobe forced low
//   flush              abort an in-flight or about-to-start read
//   io_full            IO output buffer full (stall build only)
//   lsb_rd_req         level load request, held until lsb_rd_done
//   lsb_wr_req         one-cycle store pulse
//   lsb_len/addr/wdata access size in bits, byte address, store data
//   lsb_rd_done/rdata  load-complete pulse and zero-extended data
//   lsb_wr_done        store-complete pulse
//   if_req/if_addr     level 32-bit fetch request and address
//   if_done/if_data    fetch-complete pulse and instruction word
//   mem_din            RAM read byte, valid the cycle after mem_a
//   mem_dout/mem_a     write byte and byte address
//   mem_wr             write strobe
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_TAG = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              io_full,

    input  logic              lsb_rd_req,
    input  logic              lsb_wr_req,
    input  logic [5:0]        lsb_len,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_rd_done,
    output logic [31:0]       lsb_rdata,
    output logic              lsb_wr_done,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,

    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        n;
        logic [31:0]       data;
    } wreq_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Byte count from lsb_len[5:3]; zero means one byte, anything above a
    // word is clamped to four bytes since the data paths are 32 bits wide.
    function automatic logic [2:0] byte_cnt(input logic [2:0] f);
        logic [2:0] n;
        n = f;
        if (n == 3'd0)
            n = 3'd1;
        else if (n > 3'd4)
            n = 3'd4;
        return n;
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[17:16] == IO_TAG;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        cur_n_q, cur_n_d;
    logic              cur_lsb_q, cur_lsb_d;   // read owner: 1 = LSB, 0 = fetch
    logic              cur_io_q, cur_io_d;
    logic [31:0]       cur_data_q, cur_data_d;
    logic [31:0]       rd_buf_q, rd_buf_d;
    wreq_t             pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;

    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              lsb_rd_done_q, lsb_rd_done_d;
    logic              lsb_wr_done_q, lsb_wr_done_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_data_q, if_data_d;

    wreq_t             live;
    wreq_t             wsel;
    logic [2:0]        k;       // index of the edge being taken, counted from E0
    logic [1:0]        bidx;    // byte slot captured on this read edge
    logic              stall;

    assign live = wreq_t'{addr: lsb_addr, n: byte_cnt(lsb_len[5:3]), data: lsb_wdata};
    assign wsel = pend_vld_q ? pend_q : live;
    assign k    = cnt_q + 3'd1;
    assign bidx = k[1:0] - 2'd2;

`ifdef MEM_IO_STALL_EN
    assign stall = (state_q == WRITE) && cur_io_q && io_full;
`else
    assign stall = 1'b0;
`endif

    logic unused;
    assign unused = ^{lsb_len[2:0], io_full, cur_io_q};

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_n_d       = cur_n_q;
        cur_lsb_d     = cur_lsb_q;
        cur_io_d      = cur_io_q;
        cur_data_d    = cur_data_q;
        rd_buf_d      = rd_buf_q;
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = mem_wr_q;
        lsb_rd_done_d = lsb_rd_done_q;
        lsb_wr_done_d = lsb_wr_done_q;
        lsb_rdata_d   = lsb_rdata_q;
        if_done_d     = if_done_q;
        if_data_d     = if_data_q;

        if (rdy) begin
            lsb_rd_done_d = 1'b0;
            lsb_wr_done_d = 1'b0;
            if_done_d     = 1'b0;

            // A store pulse that cannot be taken directly is parked. In IDLE
            // without flush it is taken directly below instead.
            if (lsb_wr_req && !pend_vld_q && (state_q != IDLE || flush)) begin
                pend_d     = live;
                pend_vld_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (!flush) begin
                        if (pend_vld_q || lsb_wr_req) begin
                            pend_vld_d = 1'b0;
                            state_d    = WRITE;
                            cnt_d      = 3'd0;
                            mem_a_d    = wsel.addr;
                            mem_dout_d = wsel.data[7:0];
                            mem_wr_d   = 1'b1;
                            cur_n_d    = wsel.n;
                            cur_data_d = wsel.data;
                            cur_io_d   = is_io(wsel.addr);
                        end else if (lsb_rd_req) begin
                            state_d   = READ;
                            cnt_d     = 3'd0;
                            mem_a_d   = lsb_addr;
                            cur_n_d   = byte_cnt(lsb_len[5:3]);
                            cur_lsb_d = 1'b1;
                            rd_buf_d  = 32'd0;
                        end else if (if_req) begin
                            state_d   = READ;
                            cnt_d     = 3'd0;
                            mem_a_d   = if_addr;
                            cur_n_d   = 3'd4;
                            cur_lsb_d = 1'b0;
                            rd_buf_d  = 32'd0;
                        end
                    end
                end

                READ: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = k;
                        if (k < cur_n_q)
                            mem_a_d = mem_a_q + ONE;
                        // RAM returns byte i two edges after its address left
                        // this block; unused upper bytes stay zero.
                        if (k >= 3'd2)
                            rd_buf_d[{bidx, 3'b000} +: 8] = mem_din;
                        if (k == cur_n_q + 3'd1) begin
                            state_d = DONE;
                            if (cur_lsb_q) begin
                                lsb_rd_done_d = 1'b1;
                                lsb_rdata_d   = rd_buf_d;
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = rd_buf_d;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (!stall) begin
                        cnt_d = k;
                        if (k < cur_n_q) begin
                            mem_a_d    = mem_a_q + ONE;
                            mem_dout_d = cur_data_q[{k[1:0], 3'b000} +: 8];
                        end else begin
                            mem_wr_d      = 1'b0;
                            lsb_wr_done_d = 1'b1;
                            state_d       = DONE;
                        end
                    end
                end

                // One dead cycle so a still-held level request is not taken twice.
                DONE: state_d = IDLE;

                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            cur_n_q       <= 3'd0;
            cur_lsb_q     <= 1'b0;
            cur_io_q      <= 1'b0;
            cur_data_q    <= 32'd0;
            rd_buf_q      <= 32'd0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            mem_a_q       <= '0;
            mem_dout_q    <= 8'd0;
            mem_wr_q      <= 1'b0;
            lsb_rd_done_q <= 1'b0;
            lsb_wr_done_q <= 1'b0;
            lsb_rdata_q   <= 32'd0;
            if_done_q     <= 1'b0;
            if_data_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_n_q       <= cur_n_d;
            cur_lsb_q     <= cur_lsb_d;
            cur_io_q      <= cur_io_d;
            cur_data_q    <= cur_data_d;
            rd_buf_q      <= rd_buf_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            lsb_rd_done_q <= lsb_rd_done_d;
            lsb_wr_done_q <= lsb_wr_done_d;
            lsb_rdata_q   <= lsb_rdata_d;
            if_done_q     <= if_done_d;
            if_data_q     <= if_data_d;
        end
    end

    // Strobe is gated combinationally so rdy / IO stall take effect at once.
    assign mem_wr      = mem_wr_q & rdy & ~stall;
    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign lsb_rd_done = lsb_rd_done_q;
    assign lsb_wr_done = lsb_wr_done_q;
    assign lsb_rdata   = lsb_rdata_q;
    assign if_done     = if_done_q;
    assign if_data     = if_data_q;

endmodule
